// File: rtl/pooled_map_collector.sv
// Collects strobed max-pool results into a QxQ row-major buffer and streams the finished map out
// over valid/ready/last. Optional COLLECTOR_DROP_COUNT_EN adds a saturating drop_count output.
module pooled_map_collector #(
    parameter int M      = 26,
    parameter int P      = 2,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              external_reset,
    input  logic              pool_valid,
    input  logic [DATA_W-1:0] pool_data,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
`ifdef COLLECTOR_DROP_COUNT_EN
    ,
    output logic [15:0]       drop_count
`endif
);

    localparam int Q     = M / P;
    localparam int DEPTH = Q * Q;
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [DATA_W-1:0] mem_r [DEPTH];

    logic [1:0]       state_r;
    logic [1:0]       state_nx_s;
    logic [IDX_W-1:0] wr_idx_r;
    logic [IDX_W-1:0] wr_idx_nx_s;
    logic [IDX_W-1:0] rd_idx_r;
    logic [IDX_W-1:0] rd_idx_nx_s;
    logic [IDX_W-1:0] rd_addr_s;
    logic             wr_en_s;
    logic             load_s;
    logic             tvalid_nx_s;
    logic             tlast_nx_s;
    logic             done_nx_s;
    logic             ovf_nx_s;

    // Next-state and output-register decode for the fill/drain sequencer
    always_comb begin
        state_nx_s  = state_r;
        wr_idx_nx_s = wr_idx_r;
        rd_idx_nx_s = rd_idx_r;
        rd_addr_s   = IDX_ZERO;
        wr_en_s     = 1'b0;
        load_s      = 1'b0;
        tvalid_nx_s = m_tvalid;
        tlast_nx_s  = m_tlast;
        done_nx_s   = 1'b0;
        ovf_nx_s    = overflow;

        case (state_r)
            ST_IDLE: begin
                if (pool_valid) begin
                    wr_en_s     = 1'b1;
                    wr_idx_nx_s = IDX_ONE;
                    state_nx_s  = ST_FILL;
                end else begin
                    state_nx_s  = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (pool_valid) begin
                    wr_en_s = 1'b1;
                    if (wr_idx_r == IDX_LAST) begin
                        // Preload element 0 so valid data is presented the cycle after the last write
                        state_nx_s  = ST_DRAIN;
                        rd_idx_nx_s = IDX_ZERO;
                        rd_addr_s   = IDX_ZERO;
                        load_s      = 1'b1;
                        tvalid_nx_s = 1'b1;
                        tlast_nx_s  = 1'b0;
                    end else begin
                        wr_idx_nx_s = wr_idx_r + IDX_ONE;
                    end
                end else begin
                    state_nx_s = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (pool_valid) begin
                    ovf_nx_s = 1'b1;
                end else begin
                    ovf_nx_s = overflow;
                end
                if (m_tvalid && m_tready) begin
                    if (rd_idx_r == IDX_LAST) begin
                        state_nx_s  = ST_IDLE;
                        wr_idx_nx_s = IDX_ZERO;
                        rd_idx_nx_s = IDX_ZERO;
                        tvalid_nx_s = 1'b0;
                        tlast_nx_s  = 1'b0;
                        done_nx_s   = 1'b1;
                    end else begin
                        rd_idx_nx_s = rd_idx_r + IDX_ONE;
                        rd_addr_s   = rd_idx_r + IDX_ONE;
                        load_s      = 1'b1;
                        tlast_nx_s  = ((rd_idx_r + IDX_ONE) == IDX_LAST);
                    end
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            default: begin
                state_nx_s  = ST_IDLE;
                wr_idx_nx_s = IDX_ZERO;
                rd_idx_nx_s = IDX_ZERO;
                tvalid_nx_s = 1'b0;
                tlast_nx_s  = 1'b0;
            end
        endcase
    end

    // Map buffer: one write port, contents need no reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_idx_r] <= pool_data;
        end
    end

    // Sequencer state, indices and registered stream outputs
    always_ff @(posedge clk or posedge external_reset) begin
        if (external_reset) begin
            state_r    <= ST_IDLE;
            wr_idx_r   <= IDX_ZERO;
            rd_idx_r   <= IDX_ZERO;
            m_tdata    <= {DATA_W{1'b0}};
            m_tvalid   <= 1'b0;
            m_tlast    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            wr_idx_r   <= wr_idx_nx_s;
            rd_idx_r   <= rd_idx_nx_s;
            m_tvalid   <= tvalid_nx_s;
            m_tlast    <= tlast_nx_s;
            busy       <= (state_nx_s != ST_IDLE);
            frame_done <= done_nx_s;
            overflow   <= ovf_nx_s;
            if (load_s) begin
                m_tdata <= mem_r[rd_addr_s];
            end
        end
    end

`ifdef COLLECTOR_DROP_COUNT_EN
    logic drop_s;

    // Any strobe arriving while draining is discarded
    always_comb begin
        drop_s = 1'b0;
        if ((state_r == ST_DRAIN) && pool_valid) begin
            drop_s = 1'b1;
        end else begin
            drop_s = 1'b0;
        end
    end

    // Saturating count of discarded strobes
    always_ff @(posedge clk or posedge external_reset) begin
        if (external_reset) begin
            drop_count <= 16'h0000;
        end else if (drop_s && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_pooled_map_collector.sv
// Directed bench for pooled_map_collector with M=4, P=2 (2x2 map, DEPTH=4).
module tb_pooled_map_collector;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              external_reset;
    logic              pool_valid;
    logic [DATA_W-1:0] pool_data;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    logic              busy;
    logic              frame_done;
    logic              overflow;
`ifdef COLLECTOR_DROP_COUNT_EN
    logic [15:0]       drop_count;
`endif

    int errors = 0;
    int checks = 0;

    pooled_map_collector #(.M(4), .P(2), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .external_reset (external_reset),
        .pool_valid     (pool_valid),
        .pool_data      (pool_data),
        .m_tdata        (m_tdata),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .m_tlast        (m_tlast),
        .busy           (busy),
        .frame_done     (frame_done),
        .overflow       (overflow)
`ifdef COLLECTOR_DROP_COUNT_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        pool_valid = 1'b1;
        pool_data  = d;
        tick();
        pool_valid = 1'b0;
        pool_data  = 16'h0000;
    endtask

    task automatic beat(input string tag, input logic [DATA_W-1:0] d, input logic last);
        chk({tag, "_valid"}, {31'd0, m_tvalid}, 32'd1);
        chk({tag, "_data"},  {16'd0, m_tdata},  {16'd0, d});
        chk({tag, "_last"},  {31'd0, m_tlast},  {31'd0, last});
    endtask

    // Expects the first element already presented; drains the rest with m_tready=1
    task automatic drain4(input string tag, input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                          input logic [DATA_W-1:0] d2, input logic [DATA_W-1:0] d3);
        beat({tag, "_b0"}, d0, 1'b0);
        tick();
        beat({tag, "_b1"}, d1, 1'b0);
        tick();
        beat({tag, "_b2"}, d2, 1'b0);
        tick();
        beat({tag, "_b3"}, d3, 1'b1);
        tick();
        chk({tag, "_done"},   {31'd0, frame_done}, 32'd1);
        chk({tag, "_vld0"},   {31'd0, m_tvalid},   32'd0);
        chk({tag, "_last0"},  {31'd0, m_tlast},    32'd0);
        chk({tag, "_idle"},   {31'd0, busy},       32'd0);
    endtask

    initial begin
        external_reset = 1'b1;
        pool_valid     = 1'b0;
        pool_data      = 16'h0000;
        m_tready       = 1'b1;
        tick();
        tick();
        chk("rst_tdata",  {16'd0, m_tdata},    32'd0);
        chk("rst_tvalid", {31'd0, m_tvalid},   32'd0);
        chk("rst_tlast",  {31'd0, m_tlast},    32'd0);
        chk("rst_busy",   {31'd0, busy},       32'd0);
        chk("rst_done",   {31'd0, frame_done}, 32'd0);
        chk("rst_ovf",    {31'd0, overflow},   32'd0);
`ifdef COLLECTOR_DROP_COUNT_EN
        chk("rst_drops",  {16'd0, drop_count}, 32'd0);
`endif
        external_reset = 1'b0;
        tick();

        // Test 1/2: fill with gaps, then drain without back-pressure
        push(16'd5);
        chk("t1_busy",   {31'd0, busy},     32'd1);
        chk("t1_novld",  {31'd0, m_tvalid}, 32'd0);
        tick();
        push(16'd9);
        tick();
        tick();
        push(16'd3);
        chk("t1_novld3", {31'd0, m_tvalid}, 32'd0);
        tick();
        push(16'd7);
        drain4("t2", 16'd5, 16'd9, 16'd3, 16'd7);
        tick();
        chk("t2_done1",  {31'd0, frame_done}, 32'd0);
        chk("t2_ovf",    {31'd0, overflow},   32'd0);

        // Test 3: stall three cycles while 9 is presented
        push(16'd5);
        push(16'd9);
        push(16'd3);
        push(16'd7);
        beat("t3_b0", 16'd5, 1'b0);
        tick();
        beat("t3_b1", 16'd9, 1'b0);
        m_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            beat("t3_hold", 16'd9, 1'b0);
        end
        m_tready = 1'b1;
        tick();
        beat("t3_b2", 16'd3, 1'b0);
        tick();
        beat("t3_b3", 16'd7, 1'b1);
        tick();
        chk("t3_done", {31'd0, frame_done}, 32'd1);
        chk("t3_ovf",  {31'd0, overflow},   32'd0);
        tick();

        // Test 4: strobe during drain is dropped and flagged
        push(16'd5);
        push(16'd9);
        push(16'd3);
        push(16'd7);
        beat("t4_b0", 16'd5, 1'b0);
        push(16'd42);
        chk("t4_ovf", {31'd0, overflow}, 32'd1);
        beat("t4_b1", 16'd9, 1'b0);
        tick();
        beat("t4_b2", 16'd3, 1'b0);
        tick();
        beat("t4_b3", 16'd7, 1'b1);
        tick();
        chk("t4_done",    {31'd0, frame_done}, 32'd1);
        chk("t4_ovf_stk", {31'd0, overflow},   32'd1);
`ifdef COLLECTOR_DROP_COUNT_EN
        chk("t4_drops",   {16'd0, drop_count}, 32'd1);
`endif
        tick();
        chk("t4_ovf_stk2", {31'd0, overflow}, 32'd1);

        // Test 5: asynchronous reset after two writes
        push(16'd11);
        push(16'd12);
        chk("t5_busy_pre", {31'd0, busy}, 32'd1);
        #2;
        external_reset = 1'b1;
        #1;
        chk("t5_busy",  {31'd0, busy},       32'd0);
        chk("t5_ovf",   {31'd0, overflow},   32'd0);
        chk("t5_vld",   {31'd0, m_tvalid},   32'd0);
        chk("t5_done",  {31'd0, frame_done}, 32'd0);
        chk("t5_tdata", {16'd0, m_tdata},    32'd0);
        tick();
        external_reset = 1'b0;
        tick();
        push(16'd1);
        push(16'd2);
        push(16'd3);
        push(16'd4);
        drain4("t5", 16'd1, 16'd2, 16'd3, 16'd4);
        tick();

        // Test 6: back-to-back frames
        push(16'd10);
        push(16'd20);
        push(16'd30);
        push(16'd40);
        drain4("t6a", 16'd10, 16'd20, 16'd30, 16'd40);
        push(16'd50);
        push(16'd60);
        push(16'd70);
        push(16'd80);
        drain4("t6b", 16'd50, 16'd60, 16'd70, 16'd80);
        chk("t6_ovf", {31'd0, overflow}, 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
